// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between the program counter and IF/ID.
// Issues one request/acknowledge read at a time, advances the PC with a
// single-cycle pc_write_o pulse per issued fetch, and hands instructions to
// decode through a 2-entry FIFO with a valid/ready handshake.
// Optional build macro FETCH_STATS_EN adds saturating fetch/drop counters.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no request outstanding
// WAIT    | request outstanding, result will be pushed into the buffer
// DROP    | request outstanding but flushed, result will be discarded
module fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pc_write_o,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    input  logic              flush_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [DATA_W-1:0] id_instr_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [ADDR_W-1:0] id_pc4_o
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]       stat_fetch_o,
    output logic [15:0]       stat_drop_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              issue;
    logic              push;
    logic              pop;
    logic [1:0]        count_q;
    logic [1:0]        count_after;
    logic [DATA_W-1:0] e0_instr, e1_instr;
    logic [ADDR_W-1:0] e0_pc, e1_pc;

    // Head of the buffer is always entry 0; it is left untouched when the
    // buffer drains or is flushed, so the id_* outputs hold their last value.
    assign id_valid_o  = (count_q != 2'd0);
    assign pop         = id_valid_o && id_ready_i;
    assign count_after = count_q + 2'd1 - {1'b0, pop};
    assign id_instr_o  = e0_instr;
    assign id_pc_o     = e0_pc;
    assign id_pc4_o    = e0_pc + ADDR_W'(4);
    // Held low during reset so the PC never advances while the block is in reset.
    assign pc_write_o  = issue && rst_n;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state, issue and push decisions.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!flush_i && count_q < 2'd2) begin
                    issue   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ack_i) begin
                    if (flush_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        push = 1'b1;
                        if (count_after < 2'd2) begin
                            issue   = 1'b1;
                            state_d = ST_WAIT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else if (flush_i) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem_ack_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory request and address; address only changes when a new fetch issues.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            imem_req_o  <= 1'b0;
            imem_addr_o <= '0;
        end else if (issue) begin
            imem_req_o  <= 1'b1;
            imem_addr_o <= pc_i;
        end else if (state_q != ST_IDLE && imem_ack_i) begin
            imem_req_o  <= 1'b0;
        end
    end

    // Two-entry FIFO; flush wins over push and pop. A push never lands on a
    // full buffer because issue is only allowed when room is guaranteed.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            e0_instr <= '0;
            e0_pc    <= '0;
            e1_instr <= '0;
            e1_pc    <= '0;
        end else if (flush_i) begin
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        e0_instr <= imem_rdata_i;
                        e0_pc    <= imem_addr_o;
                    end else begin
                        e1_instr <= imem_rdata_i;
                        e1_pc    <= imem_addr_o;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        e0_instr <= e1_instr;
                        e0_pc    <= e1_pc;
                    end
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        e0_instr <= e1_instr;
                        e0_pc    <= e1_pc;
                        e1_instr <= imem_rdata_i;
                        e1_pc    <= imem_addr_o;
                    end else begin
                        e0_instr <= imem_rdata_i;
                        e0_pc    <= imem_addr_o;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    logic        ack_drop;
    logic [1:0]  drop_inc;
    logic [16:0] fetch_sum;
    logic [16:0] drop_sum;

    assign ack_drop  = imem_ack_i &&
                       (state_q == ST_DROP || (state_q == ST_WAIT && flush_i));
    assign drop_inc  = (flush_i ? count_q : 2'd0) + {1'b0, ack_drop};
    assign fetch_sum = {1'b0, stat_fetch_o} + {16'd0, push};
    assign drop_sum  = {1'b0, stat_drop_o} + {15'd0, drop_inc};

    // Saturating event counters.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetch_o <= 16'd0;
            stat_drop_o  <= 16'd0;
        end else begin
            stat_fetch_o <= fetch_sum[16] ? 16'hFFFF : fetch_sum[15:0];
            stat_drop_o  <= drop_sum[16]  ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a small PC model and a
// memory responder (fixed ack delay or manually driven ack).
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_q;
    logic        pc_write_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        flush_i = 1'b0;
    logic        id_valid_o;
    logic        id_ready_i = 1'b1;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc4_o;
`ifdef FETCH_STATS_EN
    logic [15:0] stat_fetch_o;
    logic [15:0] stat_drop_o;
`endif

    logic [31:0] pc_start = 32'd0;
    logic [31:0] redir_pc = 32'd0;
    logic        redir_en = 1'b0;
    logic        manual   = 1'b0;
    logic        man_ack  = 1'b0;
    logic        bad_data = 1'b0;
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    int          checks = 0;
    int          errors = 0;

    fetch_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .pc_i         (pc_q),
        .pc_write_o   (pc_write_o),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .flush_i      (flush_i),
        .id_valid_o   (id_valid_o),
        .id_ready_i   (id_ready_i),
        .id_instr_o   (id_instr_o),
        .id_pc_o      (id_pc_o),
        .id_pc4_o     (id_pc4_o)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetch_o (stat_fetch_o),
        .stat_drop_o  (stat_drop_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Program counter model: start value in reset, redirect, else +4 per pc_write.
    always @(posedge clk_i) begin
        if (!rst_n)         pc_q <= pc_start;
        else if (redir_en)  pc_q <= redir_pc;
        else if (pc_write_o) pc_q <= pc_q + 32'd4;
    end

    // Memory responder: counts cycles a request has been waiting.
    always @(posedge clk_i) begin
        if (!imem_req_o || imem_ack_i) wait_cnt <= 0;
        else                           wait_cnt <= wait_cnt + 1;
    end

    assign imem_ack_i   = imem_req_o && (manual ? man_ack : (wait_cnt >= ack_delay));
    assign imem_rdata_i = bad_data ? 32'hDEAD_BEEF : ~imem_addr_o;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] start);
        rst_n    = 1'b0;
        flush_i  = 1'b0;
        redir_en = 1'b0;
        pc_start = start;
        repeat (2) step();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int pw;
        int pops;
        logic [31:0] exp_pc;

        // Reset values, then single-cycle ack streaming from PC 0.
        repeat (2) step();
        check("rst_req",    32'(imem_req_o), 32'd0);
        check("rst_addr",   imem_addr_o,     32'd0);
        check("rst_pw",     32'(pc_write_o), 32'd0);
        check("rst_valid",  32'(id_valid_o), 32'd0);
        check("rst_instr",  id_instr_o,      32'd0);
        check("rst_pc",     id_pc_o,         32'd0);
        check("rst_pc4",    id_pc4_o,        32'd4);
`ifdef FETCH_STATS_EN
        check("rst_sfetch", 32'(stat_fetch_o), 32'd0);
        check("rst_sdrop",  32'(stat_drop_o),  32'd0);
`endif
        rst_n = 1'b1;
        #1;
        check("t1_pw_c0", 32'(pc_write_o), 32'd1);
        step();
        check("t1_req_c1",   32'(imem_req_o), 32'd1);
        check("t1_addr_c1",  imem_addr_o,     32'd0);
        check("t1_valid_c1", 32'(id_valid_o), 32'd0);
        check("t1_pw_c1",    32'(pc_write_o), 32'd1);
        step();
        check("t1_valid_c2", 32'(id_valid_o), 32'd1);
        check("t1_pc_c2",    id_pc_o,         32'h0);
        check("t1_instr_c2", id_instr_o,      32'hFFFF_FFFF);
        check("t1_pw_c2",    32'(pc_write_o), 32'd1);
        step();
        check("t1_pc_c3",    id_pc_o,         32'h4);
        check("t1_pc4_c3",   id_pc4_o,        32'h8);
        check("t1_pw_c3",    32'(pc_write_o), 32'd1);
        step();
        check("t1_pc_c4",    id_pc_o,         32'h8);
        check("t1_valid_c4", 32'(id_valid_o), 32'd1);

        // Ack delayed by 3 cycles.
        ack_delay  = 3;
        id_ready_i = 1'b1;
        do_reset(32'h100);
        pw = pc_write_o ? 1 : 0;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (pc_write_o) pw++;
            if (i <= 4) begin
                check("t2_req_hold",  32'(imem_req_o), 32'd1);
                check("t2_addr_hold", imem_addr_o,     32'h100);
            end
            if (i == 4) check("t2_valid_at_ack", 32'(id_valid_o), 32'd0);
            if (i == 5) begin
                check("t2_valid_after", 32'(id_valid_o), 32'd1);
                check("t2_pc_after",    id_pc_o,         32'h100);
            end
            if (i == 6) check("t2_valid_popped", 32'(id_valid_o), 32'd0);
        end
        check("t2_pw_pulses", 32'(pw), 32'd2);

        // Back-pressure: ready low, buffer fills to 2 and issue stops.
        ack_delay  = 0;
        id_ready_i = 1'b0;
        do_reset(32'h200);
        repeat (3) step();
        check("t3_full_valid", 32'(id_valid_o), 32'd1);
        check("t3_full_head",  id_pc_o,         32'h200);
        for (int i = 0; i < 7; i++) begin
            check("t3_full_pw",  32'(pc_write_o), 32'd0);
            check("t3_full_req", 32'(imem_req_o), 32'd0);
            step();
        end
        id_ready_i = 1'b1;
        #1;
        exp_pc = 32'h200;
        pops   = 0;
        for (int i = 0; i < 10; i++) begin
            if (id_valid_o && id_ready_i) begin
                check("t3_pop_pc",    id_pc_o,    exp_pc);
                check("t3_pop_instr", id_instr_o, ~exp_pc);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            step();
        end
        check("t3_pop_count", 32'(pops), 32'd9);

        // Flush while waiting; late ack carries 0xDEADBEEF and must be dropped.
        manual     = 1'b1;
        man_ack    = 1'b0;
        id_ready_i = 1'b1;
        do_reset(32'h300);
        step();
        check("t4_req_c1",  32'(imem_req_o), 32'd1);
        check("t4_addr_c1", imem_addr_o,     32'h300);
        flush_i  = 1'b1;
        redir_en = 1'b1;
        redir_pc = 32'h400;
        #1;
        check("t4_pw_flush", 32'(pc_write_o), 32'd0);
        step();
        flush_i  = 1'b0;
        redir_en = 1'b0;
        #1;
        check("t4_drop_req",   32'(imem_req_o), 32'd1);
        check("t4_drop_addr",  imem_addr_o,     32'h300);
        check("t4_drop_pw",    32'(pc_write_o), 32'd0);
        check("t4_drop_valid", 32'(id_valid_o), 32'd0);
        step();
        man_ack  = 1'b1;
        bad_data = 1'b1;
        #1;
        check("t4_ack_pw", 32'(pc_write_o), 32'd0);
        step();
        man_ack  = 1'b0;
        bad_data = 1'b0;
        #1;
        check("t4_after_req",   32'(imem_req_o), 32'd0);
        check("t4_after_valid", 32'(id_valid_o), 32'd0);
        check("t4_after_pw",    32'(pc_write_o), 32'd1);
        step();
        check("t4_new_req",  32'(imem_req_o), 32'd1);
        check("t4_new_addr", imem_addr_o,     32'h400);
        man_ack = 1'b1;
        #1;
        step();
        man_ack = 1'b0;
        #1;
        check("t4_new_valid", 32'(id_valid_o), 32'd1);
        check("t4_new_pc",    id_pc_o,         32'h400);
        check("t4_new_instr", id_instr_o,      ~32'h400);

        // Flush coinciding with ack while one entry is buffered, then flush a full buffer.
        manual     = 1'b0;
        ack_delay  = 0;
        id_ready_i = 1'b0;
        do_reset(32'h500);
        repeat (2) step();
        check("t5_pre_valid", 32'(id_valid_o), 32'd1);
        check("t5_pre_pc",    id_pc_o,         32'h500);
        check("t5_pre_req",   32'(imem_req_o), 32'd1);
        flush_i    = 1'b1;
        id_ready_i = 1'b1;
        redir_en   = 1'b1;
        redir_pc   = 32'h600;
        #1;
        check("t5_flush_pw", 32'(pc_write_o), 32'd0);
        step();
        flush_i    = 1'b0;
        redir_en   = 1'b0;
        id_ready_i = 1'b0;
        #1;
        check("t5_post_valid", 32'(id_valid_o), 32'd0);
        check("t5_post_req",   32'(imem_req_o), 32'd0);
        check("t5_post_head",  id_pc_o,         32'h500);
        check("t5_post_pw",    32'(pc_write_o), 32'd1);
`ifdef FETCH_STATS_EN
        check("t5_sfetch_a", 32'(stat_fetch_o), 32'd1);
        check("t5_sdrop_a",  32'(stat_drop_o),  32'd2);
`endif
        repeat (3) step();
        check("t5_full_valid", 32'(id_valid_o), 32'd1);
        check("t5_full_req",   32'(imem_req_o), 32'd0);
        check("t5_full_head",  id_pc_o,         32'h600);
        flush_i = 1'b1;
        #1;
        check("t5_full_flush_pw", 32'(pc_write_o), 32'd0);
        step();
        flush_i = 1'b0;
        #1;
        check("t5_empty_valid", 32'(id_valid_o), 32'd0);
        check("t5_empty_head",  id_pc_o,         32'h600);
`ifdef FETCH_STATS_EN
        check("t5_sfetch_b", 32'(stat_fetch_o), 32'd3);
        check("t5_sdrop_b",  32'(stat_drop_o),  32'd4);
`endif

        // Address wrap, then asynchronous reset while a request is outstanding.
        id_ready_i = 1'b0;
        do_reset(32'hFFFF_FFFC);
        repeat (2) step();
        check("t6_valid", 32'(id_valid_o), 32'd1);
        check("t6_pc",    id_pc_o,         32'hFFFF_FFFC);
        check("t6_pc4",   id_pc4_o,        32'h0000_0000);
        check("t6_req",   32'(imem_req_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_req",   32'(imem_req_o), 32'd0);
        check("t6_rst_pw",    32'(pc_write_o), 32'd0);
        check("t6_rst_valid", 32'(id_valid_o), 32'd0);
        check("t6_rst_pc4",   id_pc4_o,        32'd4);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
